rle_zigzag_expander: RTL and testbench
======================================

Name: rle_zigzag_expander

Overview:
- Upstream neighbour of decompressor_top: turns entropy-decoded (run, level) symbols into complete 8x8 blocks of quantized coefficients.
- Output coefficients are in natural (row-major) order within each block, ready for the dequant/IDCT path.
- Symbols are in zigzag scan order; each block is terminated by an EOB symbol or by filling position 63.
- Emits one block at a time over a valid/ready handshake.

Parameters:
- COEF_W, 9, signed coefficient width (matches decompressor coefficient input)
- RUN_W, 6, width of the zero-run field
- NUM_COEF, 64, coefficients per block (fixed 8x8; other values unsupported)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- sym_valid  in  1  symbol present
- sym_ready  out  1  expander accepts symbol this cycle
- sym_run  in  RUN_W  zeros preceding the level, in zigzag order
- sym_level  in  COEF_W  signed level written after the run
- sym_eob  in  1  end-of-block; sym_run and sym_level ignored when set
- blk_valid  out  1  complete block available
- blk_ready  in  1  consumer takes block
- blk_coeffs  out  NUM_COEF*COEF_W  natural-order coefficients; index k = 8*row+col at bits [k*COEF_W +: COEF_W]
- err_overflow  out  1  one-cycle pulse when a symbol's run overruns the block

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-low (rst_n).
- Reset values: state=FILL, pos=0, all buffer entries 0, blk_valid=0, err_overflow=0, sym_ready=1 after the reset cycle.
- Two states: FILL and EMIT.
- FILL:
  - sym_ready=1. A symbol is accepted when sym_valid & sym_ready.
  - Non-EOB symbol: target t = pos + sym_run.
  - If t <= 63: buf[zz[t]] <= sym_level, then pos <= t+1.
  - Level 0 is legal; it writes 0 and acts as a pure zero-run skip.
  - If t == 63 (block filled): go to EMIT; pos <= 0.
  - EOB: go to EMIT; pos <= 0. Unwritten entries stay 0.
  - EOB with pos=0 (empty block) is legal and emits all zeros.
  - Overflow, t > 63: nothing is written, err_overflow pulses the next cycle, go to EMIT with the current contents.
  - After an overflow, all following symbols belong to the next block. No resync to EOB.
- EMIT:
  - sym_ready=0, blk_valid=1, blk_coeffs stable.
  - On blk_valid & blk_ready: clear all 64 entries in that cycle, blk_valid <= 0, return to FILL.
- Latency:
  - blk_valid rises on the cycle after the completing symbol is accepted.
  - The next symbol can be accepted on the cycle after the block handshake.
  - Minimum period per block: symbols + 1 cycle.
- sym_ready is combinational from state only, never from sym_valid. blk_valid does not depend on blk_ready.
- run width: pos+sym_run is computed at RUN_W+1 bits so run=63 at pos=63 flags overflow and does not wrap.
- Reset mid-operation: a partial block is discarded, a pending output block is dropped, and the reset values apply.

Optional Feature:
- Macro DC_PRED_EN.
- Defined:
  - A level written at zigzag position 0 is a DC difference. The stored value is sat(prev_dc + level), saturated to [-256, 255].
  - prev_dc updates to the stored value at each block handshake.
  - A block ending without a position-0 write stores prev_dc at position 0.
  - prev_dc resets to 0.
- Undefined: position 0 is stored raw like any other level, and no prev_dc register exists.

Decomposition:
- Package codec_pkg:
  - localparams COEF_W, NUM_COEF, RUN_W.
  - zz[0:63] zigzag-to-natural index table (constant function or array).
  - typedef coef_t (logic signed [COEF_W-1:0]).
  - enum exp_state_t {FILL, EMIT}.
- Optional sub-module dc_predictor (saturating add plus prev_dc register), instantiated only under DC_PRED_EN.
- Everything else stays in one module.

Test Plan:
- Single symbol (run=0, level=+5) then EOB -> blk_valid after 1 cycle; coeff[0]=5, others 0; err_overflow stays 0.
- Symbols (0,3),(0,-2),(1,7), EOB -> zigzag positions 0,1,3 = natural indices 0,1,16 = 3,-2,7; rest 0.
- 64 symbols of run=0, levels 1..64 truncated to 9 bits, no EOB -> block emitted after the 64th; coeff[zz[i]]=i+1.
- pos=60 then symbol run=10 -> err_overflow pulse; block emitted with the previous 60 values; next symbol lands at position 0 of a new block.
- Backpressure: blk_ready low 5 cycles -> sym_ready=0 and blk_coeffs stable throughout; block consumed on ready; the next block has all-zero residue except its new writes.
- DC_PRED_EN: block DC diffs +100, +100, +100 -> stored DC 100, 200, 255 (saturated); rst_n low mid-fill -> next block DC diff +4 gives 4.

Source files
------------

// File: rtl/codec_pkg.sv
// ============================================================================
//  Module      : codec_pkg
//  Description : Shared types, constants and helpers for the RLE / zigzag
//                coefficient expander: block geometry, zigzag-to-natural
//                index table, coefficient type, expander FSM states and the
//                saturating DC add used when DC prediction is built in.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package codec_pkg;

    localparam int COEF_W   = 9;
    localparam int RUN_W    = 6;
    localparam int NUM_COEF = 64;

    typedef logic signed [COEF_W-1:0] coef_t;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        EMIT = 1'b1
    } exp_state_t;

    // Zigzag scan position -> natural (row-major) index, 8x8 block.
    localparam logic [5:0] ZZ [0:63] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    // Signed add of two coefficients, clamped to the coefficient range.
    function automatic coef_t sat_dc(input coef_t a, input coef_t b);
        logic signed [COEF_W:0] s;
        s = {a[COEF_W-1], a} + {b[COEF_W-1], b};
        if (s > $signed({2'b00, {(COEF_W-1){1'b1}}}))
            return {1'b0, {(COEF_W-1){1'b1}}};
        else if (s < $signed({2'b11, {(COEF_W-1){1'b0}}}))
            return {1'b1, {(COEF_W-1){1'b0}}};
        else
            return s[COEF_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/dc_predictor.sv
// ============================================================================
//  Module      : dc_predictor
//  Description : Holds the DC value of the last emitted block and forms the
//                saturated reconstruction prev_dc + level for a DC difference.
//  Ports       : clk, rst_n      - clock, synchronous active-low reset
//                i_level         - incoming DC difference
//                i_update        - block handshake; latch i_new_dc
//                i_new_dc        - DC value of the block being handed off
//                o_dc_sum        - sat(prev_dc + i_level)
//                o_prev_dc       - current prev_dc
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dc_predictor
    import codec_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  coef_t i_level,
    input  logic  i_update,
    input  coef_t i_new_dc,
    output coef_t o_dc_sum,
    output coef_t o_prev_dc
);

    coef_t r_prev_dc;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_prev_dc <= '0;
        else if (i_update)
            r_prev_dc <= i_new_dc;
    end

    assign o_dc_sum  = sat_dc(r_prev_dc, i_level);
    assign o_prev_dc = r_prev_dc;

endmodule

`default_nettype wire

// File: rtl/rle_zigzag_expander.sv
// ============================================================================
//  Module      : rle_zigzag_expander
//  Description : Expands zigzag-ordered (run, level) symbols into complete
//                8x8 blocks of quantized coefficients in natural order and
//                hands each block off over a valid/ready handshake.
//  Ports       : clk, rst_n        - clock, synchronous active-low reset
//                sym_valid/ready   - symbol handshake
//                sym_run/level/eob - symbol fields
//                blk_valid/ready   - block handshake
//                blk_coeffs        - 64 coefficients, index 8*row+col
//                err_overflow      - one-cycle pulse on run overrun
//  Config      : DC_PRED_EN - position 0 carries a DC difference that is
//                accumulated against the previous block's DC (saturating).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rle_zigzag_expander #(
    parameter int COEF_W   = 9,
    parameter int RUN_W    = 6,
    parameter int NUM_COEF = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sym_valid,
    output logic                       sym_ready,
    input  logic [RUN_W-1:0]           sym_run,
    input  logic signed [COEF_W-1:0]   sym_level,
    input  logic                       sym_eob,
    output logic                       blk_valid,
    input  logic                       blk_ready,
    output logic [NUM_COEF*COEF_W-1:0] blk_coeffs,
    output logic                       err_overflow
);

    import codec_pkg::exp_state_t;
    import codec_pkg::FILL;
    import codec_pkg::EMIT;
    import codec_pkg::ZZ;

    exp_state_t                 r_state;
    logic [RUN_W-1:0]           r_pos;
    logic signed [COEF_W-1:0]   r_buf [NUM_COEF];
    logic                       r_blk_valid;
    logic                       r_err;

    // One extra bit so an overrun is visible instead of wrapping.
    logic [RUN_W:0]             w_target;
    logic [RUN_W-1:0]           w_tidx;
    logic                       w_ovf;
    logic                       w_last;
    logic                       w_accept;
    logic                       w_finish;
    logic                       w_blk_fire;
    logic signed [COEF_W-1:0]   w_wr_val;

    assign sym_ready    = (r_state == FILL);
    assign blk_valid    = r_blk_valid;
    assign err_overflow = r_err;

    assign w_target   = {1'b0, r_pos} + {1'b0, sym_run};
    assign w_tidx     = w_target[RUN_W-1:0];
    assign w_ovf      = w_target[RUN_W];
    assign w_last     = (w_tidx == {RUN_W{1'b1}});
    assign w_accept   = sym_valid & sym_ready;
    // Any of EOB, a write to the final position, or an overrun closes the block.
    assign w_finish   = w_accept & (sym_eob | w_ovf | w_last);
    assign w_blk_fire = (r_state == EMIT) & blk_ready;

`ifdef DC_PRED_EN
    logic signed [COEF_W-1:0] w_dc_sum;
    logic signed [COEF_W-1:0] w_prev_dc;
    logic                     r_dc_written;

    dc_predictor u_dc_predictor (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_level   (sym_level),
        .i_update  (w_blk_fire),
        .i_new_dc  (r_buf[0]),
        .o_dc_sum  (w_dc_sum),
        .o_prev_dc (w_prev_dc)
    );

    assign w_wr_val = (w_tidx == '0) ? w_dc_sum : sym_level;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_dc_written <= 1'b0;
        else if (w_blk_fire)
            r_dc_written <= 1'b0;
        else if (w_accept && !sym_eob && !w_ovf && (w_tidx == '0))
            r_dc_written <= 1'b1;
    end
`else
    assign w_wr_val = sym_level;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= FILL;
            r_pos       <= '0;
            r_blk_valid <= 1'b0;
            r_err       <= 1'b0;
            for (int k = 0; k < NUM_COEF; k++)
                r_buf[k] <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        if (sym_eob) begin
                            r_pos <= '0;
                        end else if (w_ovf) begin
                            // Nothing is written; the next symbol starts a new block.
                            r_err <= 1'b1;
                            r_pos <= '0;
                        end else begin
                            r_buf[ZZ[w_tidx]] <= w_wr_val;
                            r_pos             <= w_last ? '0 : w_tidx + 1'b1;
                        end
                        if (w_finish) begin
                            r_state     <= EMIT;
                            r_blk_valid <= 1'b1;
                        end
`ifdef DC_PRED_EN
                        // A block with no DC write inherits the previous DC.
                        if (w_finish && !r_dc_written)
                            r_buf[0] <= w_prev_dc;
`endif
                    end
                end
                EMIT: begin
                    if (blk_ready) begin
                        r_state     <= FILL;
                        r_blk_valid <= 1'b0;
                        for (int k = 0; k < NUM_COEF; k++)
                            r_buf[k] <= '0;
                    end
                end
                default: begin
                    r_state     <= FILL;
                    r_blk_valid <= 1'b0;
                end
            endcase
        end
    end

    genvar gk;
    generate
        for (gk = 0; gk < NUM_COEF; gk++) begin : g_pack
            assign blk_coeffs[gk*COEF_W +: COEF_W] = r_buf[gk];
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_rle_zigzag_expander.sv
// ============================================================================
//  Module      : tb_rle_zigzag_expander
//  Description : Directed self-checking bench for rle_zigzag_expander.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rle_zigzag_expander;

    logic               clk;
    logic               rst_n;
    logic               sym_valid;
    logic               sym_ready;
    logic [5:0]         sym_run;
    logic signed [8:0]  sym_level;
    logic               sym_eob;
    logic               blk_valid;
    logic               blk_ready;
    logic [575:0]       blk_coeffs;
    logic               err_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    logic signed [8:0] e [64];

    localparam int ZZ_TB [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    rle_zigzag_expander dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sym_valid    (sym_valid),
        .sym_ready    (sym_ready),
        .sym_run      (sym_run),
        .sym_level    (sym_level),
        .sym_eob      (sym_eob),
        .blk_valid    (blk_valid),
        .blk_ready    (blk_ready),
        .blk_coeffs   (blk_coeffs),
        .err_overflow (err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [575:0] obs, input logic [575:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [575:0] pack_exp();
        logic [575:0] v;
        v = '0;
        for (int k = 0; k < 64; k++)
            v[k*9 +: 9] = e[k];
        return v;
    endfunction

    task automatic clr_exp();
        for (int k = 0; k < 64; k++)
            e[k] = '0;
    endtask

    // All tasks start and end on a falling edge.
    task automatic send(input logic [5:0] r, input logic signed [8:0] l, input logic eob);
        sym_valid = 1'b1;
        sym_run   = r;
        sym_level = l;
        sym_eob   = eob;
        @(negedge clk);
        sym_valid = 1'b0;
        sym_eob   = 1'b0;
    endtask

    task automatic consume();
        blk_ready = 1'b1;
        @(negedge clk);
        blk_ready = 1'b0;
    endtask

    task automatic do_reset();
        sym_valid = 1'b0;
        blk_ready = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
    endtask

    initial begin
        sym_valid = 1'b0;
        sym_run   = '0;
        sym_level = '0;
        sym_eob   = 1'b0;
        blk_ready = 1'b0;
        rst_n     = 1'b0;
        clr_exp();
        @(negedge clk);
        do_reset();

        chk1("reset_sym_ready", sym_ready, 1'b1);
        chk1("reset_blk_valid", blk_valid, 1'b0);
        chk1("reset_err", err_overflow, 1'b0);
        chkv("reset_coeffs", blk_coeffs, '0);

`ifdef DC_PRED_EN
        // DC accumulation with saturation
        send(6'd0, 9'sd100, 1'b0);
        send(6'd0, 9'sd0, 1'b1);
        clr_exp(); e[0] = 9'sd100;
        chkv("dc_blk1", blk_coeffs, pack_exp());
        consume();
        send(6'd0, 9'sd100, 1'b0);
        send(6'd0, 9'sd0, 1'b1);
        clr_exp(); e[0] = 9'sd200;
        chkv("dc_blk2", blk_coeffs, pack_exp());
        consume();
        send(6'd0, 9'sd100, 1'b0);
        send(6'd0, 9'sd0, 1'b1);
        clr_exp(); e[0] = 9'sd255;
        chkv("dc_blk3_sat", blk_coeffs, pack_exp());
        consume();
        // No DC write: inherits previous DC
        send(6'd1, 9'sd5, 1'b0);
        send(6'd0, 9'sd0, 1'b1);
        clr_exp(); e[0] = 9'sd255; e[1] = 9'sd5;
        chkv("dc_inherit", blk_coeffs, pack_exp());
        consume();
        // Reset mid-fill clears prev_dc
        send(6'd0, 9'sd3, 1'b0);
        do_reset();
        chk1("dc_rst_ready", sym_ready, 1'b1);
        send(6'd0, 9'sd4, 1'b0);
        send(6'd0, 9'sd0, 1'b1);
        clr_exp(); e[0] = 9'sd4;
        chkv("dc_after_reset", blk_coeffs, pack_exp());
        consume();
`else
        // Single symbol then EOB
        send(6'd0, 9'sd5, 1'b0);
        chk1("t1_valid_early", blk_valid, 1'b0);
        send(6'd0, 9'sd0, 1'b1);
        chk1("t1_valid", blk_valid, 1'b1);
        chk1("t1_sym_ready", sym_ready, 1'b0);
        chk1("t1_err", err_overflow, 1'b0);
        clr_exp(); e[0] = 9'sd5;
        chkv("t1_coeffs", blk_coeffs, pack_exp());
        consume();
        chk1("t1_valid_drop", blk_valid, 1'b0);
        chk1("t1_ready_back", sym_ready, 1'b1);

        // Runs and negative level
        send(6'd0, 9'sd3, 1'b0);
        send(6'd0, -9'sd2, 1'b0);
        send(6'd1, 9'sd7, 1'b0);
        send(6'd0, 9'sd0, 1'b1);
        clr_exp(); e[0] = 9'sd3; e[1] = -9'sd2; e[16] = 9'sd7;
        chkv("t2_coeffs", blk_coeffs, pack_exp());
        consume();

        // Full block, no EOB
        clr_exp();
        for (int i = 0; i < 63; i++) begin
            send(6'd0, 9'(i + 1), 1'b0);
            e[ZZ_TB[i]] = 9'(i + 1);
        end
        chk1("t3_valid_at63", blk_valid, 1'b0);
        send(6'd0, 9'sd64, 1'b0);
        e[63] = 9'sd64;
        chk1("t3_valid", blk_valid, 1'b1);
        chk1("t3_err", err_overflow, 1'b0);
        chkv("t3_coeffs", blk_coeffs, pack_exp());
        consume();

        // Overflow at pos=60 with run=10, then backpressure
        clr_exp();
        for (int i = 0; i < 60; i++) begin
            send(6'd0, 9'(i + 1), 1'b0);
            e[ZZ_TB[i]] = 9'(i + 1);
        end
        send(6'd10, 9'sd99, 1'b0);
        chk1("t4_err_pulse", err_overflow, 1'b1);
        chk1("t4_valid", blk_valid, 1'b1);
        chkv("t4_coeffs", blk_coeffs, pack_exp());
        sym_valid = 1'b1;
        sym_run   = 6'd0;
        sym_level = 9'sd77;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk1("bp_sym_ready", sym_ready, 1'b0);
            chk1("bp_valid", blk_valid, 1'b1);
            chk1("bp_err_low", err_overflow, 1'b0);
            chkv("bp_stable", blk_coeffs, pack_exp());
        end
        sym_valid = 1'b0;
        consume();
        chk1("t4_valid_drop", blk_valid, 1'b0);
        send(6'd0, -9'sd1, 1'b0);
        send(6'd0, 9'sd0, 1'b1);
        clr_exp(); e[0] = -9'sd1;
        chkv("t4_next_block", blk_coeffs, pack_exp());
        consume();

        // Run lands exactly on position 63
        send(6'd63, 9'sd9, 1'b0);
        chk1("t5_valid", blk_valid, 1'b1);
        chk1("t5_err", err_overflow, 1'b0);
        clr_exp(); e[63] = 9'sd9;
        chkv("t5_coeffs", blk_coeffs, pack_exp());
        consume();

        // Run of 63 from pos 1 overruns by one
        send(6'd0, 9'sd1, 1'b0);
        send(6'd63, 9'sd2, 1'b0);
        chk1("t6_err", err_overflow, 1'b1);
        chk1("t6_valid", blk_valid, 1'b1);
        clr_exp(); e[0] = 9'sd1;
        chkv("t6_coeffs", blk_coeffs, pack_exp());
        consume();

        // Empty block
        send(6'd0, 9'sd0, 1'b1);
        chk1("t7_valid", blk_valid, 1'b1);
        chkv("t7_coeffs", blk_coeffs, '0);
        consume();

        // Reset mid-fill discards the partial block
        send(6'd0, 9'sd9, 1'b0);
        do_reset();
        chk1("t8_ready", sym_ready, 1'b1);
        chk1("t8_valid", blk_valid, 1'b0);
        send(6'd1, 9'sd4, 1'b0);
        send(6'd0, 9'sd0, 1'b1);
        clr_exp(); e[1] = 9'sd4;
        chkv("t8_coeffs", blk_coeffs, pack_exp());

        // Reset during EMIT drops the pending block
        do_reset();
        chk1("t9_valid", blk_valid, 1'b0);
        chkv("t9_coeffs", blk_coeffs, '0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
